pipelined_adder: RTL
====================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter STAGES, default 2, giving the number of pipeline stages; WIDTH SHALL be an integer multiple of STAGES, and 1 <= STAGES <= WIDTH.
REQ-003 SHALL have one clock and an asynchronous active-high reset; these are ports clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  operands and mode are presented this cycle.
REQ-007 in_ready  output  1  block accepts an operation this cycle.
REQ-008 in_a  input  WIDTH  operand A.
REQ-009 in_b  input  WIDTH  operand B.
REQ-010 sub  input  1  0 = A+B, 1 = A-B.
REQ-011 signed_mode  input  1  1 = two's-complement overflow rule, 0 = unsigned rule.
REQ-012 out_valid  output  1  the result fields hold a completed operation.
REQ-013 out_ready  input  1  the consumer takes the result this cycle.
REQ-014 out_sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-015 carry_out  output  1  raw carry out of the MSB adder bit.
REQ-016 overflow  output  1  result is not representable under the selected mode.

Function
REQ-017 SHALL accept an operation when in_valid and in_ready are both 1.
REQ-018 SHALL transfer a result when out_valid and out_ready are both 1.
REQ-019 SHALL define advance = !out_valid | out_ready; in_ready SHALL equal advance, combinationally.
REQ-020 While advance=1, every stage SHALL shift forward one position per cycle, with bubbles carrying valid=0; while advance=0, every stage SHALL hold.
REQ-021 Latency SHALL be exactly STAGES cycles from acceptance to out_valid=1 when out_ready stays high.
REQ-022 Throughput SHALL be one operation per cycle when out_ready stays high.
REQ-023 Stage k (0-based) SHALL add slice bits [(k+1)*W/S-1 : k*W/S], using the carry registered from stage k-1.
REQ-024 Stage 0 carry-in SHALL equal sub.
REQ-025 Operand B SHALL be bitwise inverted when sub=1.
REQ-026 Operand slices not yet consumed SHALL be carried forward registered, skewed alongside their operation.
REQ-027 Unsigned mode: overflow SHALL equal carry_out when sub=0 and !carry_out (borrow) when sub=1.
REQ-028 Signed mode: overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-029 sub and signed_mode SHALL be captured at acceptance and travel with their operation; changes on later cycles SHALL NOT affect it.
REQ-030 Output fields SHALL remain stable while out_valid=1 and out_ready=0.
REQ-031 Simultaneous output transfer and input acceptance SHALL be legal in the same cycle, with no bubble inserted.
REQ-032 When STAGES=1, the block SHALL behave as a single registered adder with latency 1.

Reset
REQ-033 On rst=1, all stage valid bits, out_valid, out_sum, carry_out and overflow SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-034 Operations in flight at reset SHALL be discarded; the first operation accepted after rst deasserts SHALL produce a correct result.
REQ-035 in_ready SHALL be 1 during reset and after it, because out_valid=0.

Structure
REQ-036 Package adder_pkg SHALL hold the defaults ADDER_WIDTH_DEF=8 and ADDER_STAGES_DEF=2.
REQ-037 Package adder_pkg SHALL hold the mode encodings MODE_UNSIGNED=0 and MODE_SIGNED=1.
REQ-038 A sub-module adder_slice SHALL implement one W/S-bit ripple slice: inputs a, b and cin; outputs sum, cout and the carry into its MSB.
REQ-039 pipelined_adder SHALL instantiate adder_slice once per stage.

Verification (WIDTH=8, STAGES=2 unless stated)
REQ-040 Signed add: 0x40 + 0x60, sub=0, signed_mode=1 -> out_sum=0xA0, carry_out=0, overflow=1, after 2 cycles.
REQ-041 Unsigned wrap: 0xFF + 0x01, signed_mode=0 -> out_sum=0x00, carry_out=1, overflow=1; the same operation with signed_mode=1 -> overflow=0.
REQ-042 Subtract: 0x05 - 0x07, sub=1, unsigned -> out_sum=0xFE, carry_out=0, overflow=1; signed -> overflow=0.
REQ-043 Backpressure: 4 back-to-back operations, with out_ready=0 for 3 cycles once the first result appears -> in_ready=0 and outputs held; all 4 results then emerge in order with none lost or duplicated.
REQ-044 Reset mid-flight: assert rst with 2 operations in flight -> out_valid=0 immediately; after release, 0x10 + 0x20 -> 0x30 after 2 cycles.
REQ-045 Parameter sweep: a random self-checking run for (WIDTH,STAGES) = (4,1), (8,4) and (16,4) -> every result matches the reference model, and the latency equals STAGES.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared defaults and mode encodings for the pipelined adder and its users.
package adder_pkg;

    localparam int ADDER_WIDTH_DEF  = 8;
    localparam int ADDER_STAGES_DEF = 2;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/adder_slice.sv
// One W-bit ripple-carry slice; also exposes the carry into its MSB for signed overflow.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] carry;

    always_comb begin
        sum      = '0;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[W];
    assign cmsb = carry[W - 1];

endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract pipelined over STAGES carry-registered slices with a valid/ready handshake.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = ADDER_WIDTH_DEF,
    parameter int STAGES = ADDER_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             sub,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int SW = WIDTH / STAGES;

    logic             advance;
    logic             vld_q   [STAGES];
    logic             sub_q   [STAGES];
    logic             mode_q  [STAGES];
    logic             carry_q [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic             ovf_q;

    // The whole pipe moves together; it only freezes when a finished result is not taken.
    assign advance  = !vld_q[STAGES-1] || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             src_vld;
        logic             src_sub;
        logic             src_mode;
        logic             src_cin;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_sum;
        logic [WIDTH-1:0] nxt_sum;
        logic [SW-1:0]    slice_sum;
        logic             slice_cout;
        logic             slice_cmsb;

        if (k == 0) begin : g_head
            assign src_vld  = in_valid;
            assign src_sub  = sub;
            assign src_mode = signed_mode;
            assign src_cin  = sub;
            assign src_a    = in_a;
            assign src_b    = sub ? ~in_b : in_b;
            assign src_sum  = '0;
        end else begin : g_body
            assign src_vld  = vld_q[k-1];
            assign src_sub  = sub_q[k-1];
            assign src_mode = mode_q[k-1];
            assign src_cin  = carry_q[k-1];
            assign src_a    = a_q[k-1];
            assign src_b    = b_q[k-1];
            assign src_sum  = sum_q[k-1];
        end

        adder_slice #(.W(SW)) u_slice (
            .a    (src_a[k*SW +: SW]),
            .b    (src_b[k*SW +: SW]),
            .cin  (src_cin),
            .sum  (slice_sum),
            .cout (slice_cout),
            .cmsb (slice_cmsb)
        );

        always_comb begin
            nxt_sum             = src_sum;
            nxt_sum[k*SW +: SW] = slice_sum;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q[k]   <= 1'b0;
                carry_q[k] <= 1'b0;
                sum_q[k]   <= '0;
            end else if (advance) begin
                vld_q[k]   <= src_vld;
                carry_q[k] <= slice_cout;
                sum_q[k]   <= nxt_sum;
            end
        end

        // Mode bits and unconsumed operand slices ride along without needing a reset.
        always_ff @(posedge clk) begin
            if (advance) begin
                sub_q[k]  <= src_sub;
                mode_q[k] <= src_mode;
                a_q[k]    <= src_a;
                b_q[k]    <= src_b;
            end
        end

        if (k == STAGES - 1) begin : g_tail
            logic ovf_nxt;

            assign ovf_nxt = (src_mode == MODE_SIGNED) ? (slice_cmsb ^ slice_cout)
                                                       : (src_sub ? !slice_cout : slice_cout);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= ovf_nxt;
                end
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_sum   = sum_q[STAGES-1];
    assign carry_out = carry_q[STAGES-1];
    assign overflow  = ovf_q;

endmodule
